// File: rtl/d_sram_like_bridge_if.sv
// Sram-like split-transaction bus between the data-memory bridge (master)
// and the memory/cache side (slave): req/addr_ok address phase, data_ok data phase.
interface d_sram_like_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/d_sram_like_bridge.sv
// Bridges the M-stage data-SRAM request onto the sram-like req/addr_ok/data_ok bus.
// Optional macro DSRAM_ADDR_MAP_EN: strip the top 3 address bits of kseg0/kseg1 requests.
module d_sram_like_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_sram_en,
    input  logic [3:0]        data_sram_wen,
    input  logic [ADDR_W-1:0] data_sram_addr,
    input  logic [DATA_W-1:0] data_sram_wdata,
    output logic [DATA_W-1:0] data_sram_rdata,
    output logic              d_stall,
    input  logic              longest_stall,
    d_sram_like_bridge_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_wen;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              w_latch;
    logic              w_capture;

    // Read (wen=0) is always issued as a full word; lane select happens in M.
    function automatic logic [1:0] size_of(input logic [3:0] wen);
        logic [1:0] sz;
        case (wen)
            4'b1111:                            sz = 2'd2;
            4'b0011, 4'b1100:                   sz = 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: sz = 2'd0;
            default:                            sz = 2'd2;
        endcase
        return sz;
    endfunction

    function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] a);
`ifdef DSRAM_ADDR_MAP_EN
        logic [ADDR_W-1:0] m;
        m = a;
        if (a[ADDR_W-1 -: 2] == 2'b10)
            m = {3'b000, a[ADDR_W-4:0]};
        return m;
`else
        return a;
`endif
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (data_sram_en) w_next = S_ADDR;
            S_ADDR: if (bus.data_addr_ok) w_next = bus.data_data_ok ? S_DONE : S_DATA;
            S_DATA: if (bus.data_data_ok) w_next = S_DONE;
            S_DONE: if (!longest_stall) w_next = S_IDLE;
        endcase
    end

    // Request fields are only visible on the bus in ADDR, so they need no reset.
    always_comb begin
        bus.data_req   = 1'b0;
        bus.data_wr    = 1'b0;
        bus.data_size  = 2'd0;
        bus.data_addr  = '0;
        bus.data_wdata = '0;
        d_stall        = 1'b0;
        w_latch        = 1'b0;
        w_capture      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                d_stall = data_sram_en & rst;
                w_latch = data_sram_en;
            end
            S_ADDR: begin
                bus.data_req   = 1'b1;
                bus.data_wr    = |r_wen;
                bus.data_size  = size_of(r_wen);
                bus.data_addr  = map_addr(r_addr);
                bus.data_wdata = r_wdata;
                d_stall        = 1'b1;
                w_capture      = bus.data_addr_ok & bus.data_data_ok;
            end
            S_DATA: begin
                d_stall   = 1'b1;
                w_capture = bus.data_data_ok;
            end
            S_DONE: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_wen   <= data_sram_wen;
            r_addr  <= data_sram_addr;
            r_wdata <= data_sram_wdata;
        end
    end

    // Result is held through DONE so a frozen M stage still sees it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           r_rdata <= '0;
        else if (w_capture) r_rdata <= bus.data_rdata;
    end

    assign data_sram_rdata = r_rdata;

endmodule

// File: doc/d_sram_like_bridge.md
Name: d_sram_like_bridge

Overview:
- Sits directly downstream of the datapath's memory stage. Takes the M-stage data-SRAM request (enable, byte write-enables, address, write data) and converts it to a sram-like split-transaction handshake (req/addr_ok/data_ok).
- Generates d_stall back to the pipeline hazard unit and returns read data to M.
- Holds each completed result while any other pipeline stall (longest_stall) keeps M frozen, so no access is issued twice or lost.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32 for the MIPS core.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_sram_en  in  1  M-stage memory access valid (memen propagated to M).
- data_sram_wen  in  4  byte write enables from M; 0 means read.
- data_sram_addr  in  ADDR_W  M-stage byte address.
- data_sram_wdata  in  DATA_W  M-stage store data, already byte-lane aligned.
- data_sram_rdata  out  DATA_W  read word returned to M (lane selection is done downstream in M).
- d_stall  out  1  pipeline must freeze; access not yet complete.
- longest_stall  in  1  global pipeline freeze (OR of all stall sources), fed back from the top level.
- data_req  out  1  sram-like request valid.
- data_wr  out  1  1 = write, 0 = read.
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_addr  out  ADDR_W  request address.
- data_wdata  out  DATA_W  request write data.
- data_addr_ok  in  1  slave accepted the address phase.
- data_data_ok  in  1  slave completed the data phase; data_rdata valid this cycle.
- data_rdata  in  DATA_W  slave read data.

Behaviour:
- FSM states: IDLE, ADDR, DATA, DONE. On reset (rst=0, asynchronous):
  - state=IDLE
  - data_req=0, data_wr=0, data_size=0, data_addr=0, data_wdata=0
  - data_sram_rdata=0
- IDLE:
  - d_stall = data_sram_en (combinational, same cycle).
  - If data_sram_en, latch wen/addr/wdata into request registers and go to ADDR.
- ADDR:
  - data_req=1. Request registers are stable until addr_ok.
  - data_wr = |wen_latched.
  - data_size from the latched wen: 1111→2; 0011 or 1100→1; one-hot→0; wen=0 (read)→2.
  - data_addr = latched address, unaligned low bits passed through.
  - On addr_ok: if data_ok is also high in the same cycle, capture rdata and go to DONE; otherwise go to DATA.
  - d_stall=1.
- DATA:
  - data_req=0, d_stall=1.
  - On data_ok: capture data_rdata into data_sram_rdata (writes capture too; value is ignored) and go to DONE.
  - data_ok arriving before addr_ok is a protocol violation; it is ignored in IDLE and ADDR.
- DONE:
  - d_stall=0; data_sram_rdata holds its value.
  - If longest_stall=0, the pipeline advances this edge: go to IDLE.
  - Else stay in DONE and issue no new request, even though data_sram_en remains high.
- Latency:
  - Minimum 2 cycles of d_stall (IDLE detect + ADDR with addr_ok & data_ok together); result usable in the DONE cycle.
  - Back-to-back accesses: IDLE → ADDR is entered the cycle after DONE.
- data_sram_rdata changes only on data_ok capture or reset.
- Only one outstanding transaction; data_req is never high outside ADDR.
- Reset mid-transaction returns to IDLE immediately; a late data_ok after reset is ignored.
- An M-stage flush does not abort an issued request; the bridge completes it.

Optional Feature:
- Macro DSRAM_ADDR_MAP_EN.
- Defined:
  - data_addr applies fixed MIPS segment mapping: kseg0/kseg1 addresses (top bits 100 or 101) are emitted with the top 3 bits cleared.
  - All other addresses pass unchanged.
- Undefined: data_addr is the latched virtual address, unmodified.

Test Plan:
- Reset: hold rst=0 with random inputs → state IDLE, data_req=0, d_stall=0, data_sram_rdata=0; release, no request while en=0.
- Word read, single-cycle slave: en=1, wen=0, addr=0x1000_0040; addr_ok and data_ok both high in the ADDR cycle with rdata=0xDEAD_BEEF → d_stall high 2 cycles; data_req=1 for exactly 1 cycle; data_size=2, data_wr=0; data_sram_rdata=0xDEADBEEF in DONE.
- Byte store, delayed slave: wen=0100, wdata=0x00AB_0000, addr_ok after 3 cycles, data_ok 2 cycles later → data_wr=1, data_size=0, addr/wdata stable while req=1; d_stall deasserts only in DONE.
- Hold in DONE: complete a read with rdata=0x1234_5678 while longest_stall=1 for 4 cycles (en still high) → no second data_req; rdata stays 0x12345678; new request issued the cycle after longest_stall falls.
- Async reset during DATA: assert rst=0 between addr_ok and data_ok → outputs reset immediately; a following data_ok with rdata=0xFFFF_FFFF leaves data_sram_rdata=0.
- With DSRAM_ADDR_MAP_EN: read addr 0xBFC0_0010 → data_addr=0x1FC0_0010; addr 0x0000_0100 unchanged. Without the macro: data_addr=0xBFC0_0010.
